// File: rtl/cal_pkg.sv
// Shared calendar constants, month encodings and the month-length rule
// used by the day counter and its helpers.
package cal_pkg;

  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;

  typedef enum logic [MONTH_W-1:0] {
    JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
    MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
    SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
  } month_e;

  // Out-of-range months fall into the default and read as 31 days.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] m,
                                                     input logic leap);
    logic [DAY_W-1:0] d;
    case (m)
      FEB:                d = leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: d = 5'd30;
      default:            d = 5'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cal_dim.sv
// Combinational month-length lookup: Gregorian leap-year test on the year,
// then days in the current month.
module cal_dim
  import cal_pkg::*;
#(
  parameter int YEAR_W = 12
) (
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   dim
);

  logic leap;

  always_comb begin
    leap = ((year[1:0] == 2'b00) && ((year % YEAR_W'(100)) != '0)) ||
           ((year % YEAR_W'(400)) == '0);
    dim  = days_in_month(month, leap);
  end

endmodule

// File: rtl/cnt_day_cal.sv
// Day-of-month counter: advances on day ticks, wraps at month end and
// emits a one-cycle inc_month pulse that clocks the month counter.
module cnt_day_cal
  import cal_pkg::*;
#(
  parameter int YEAR_W  = 12,
  parameter int DAY_RST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_day,
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  input  logic               load,
  input  logic [DAY_W-1:0]   load_day,
  output logic [DAY_W-1:0]   day,
  output logic               inc_month,
  output logic [DAY_W-1:0]   dim
);

  logic [DAY_W-1:0] load_val;

  cal_dim #(.YEAR_W(YEAR_W)) u_dim (
    .month (month),
    .year  (year),
    .dim   (dim)
  );

  // Clamp a requested load into the legal 1..dim range of the current month.
  always_comb begin
    load_val = load_day;
    if (load_day == '0)
      load_val = DAY_W'(1);
    else if (load_day > dim)
      load_val = dim;
  end

  // >= rather than == so a day stranded above a shortened month wraps on the next tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      day       <= DAY_W'(DAY_RST);
      inc_month <= 1'b0;
    end else if (load) begin
      day       <= load_val;
      inc_month <= 1'b0;
    end else if (inc_day) begin
      if (day >= dim) begin
        day       <= DAY_W'(1);
        inc_month <= 1'b1;
      end else begin
        day       <= day + DAY_W'(1);
        inc_month <= 1'b0;
      end
    end else begin
      inc_month <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt_day_cal.sv
// Scoreboard bench for cnt_day_cal: directed calendar cases plus random
// traffic checked against a plain-arithmetic calendar model.
module tb_cnt_day_cal;

  logic        clk = 1'b0;
  logic        rst;
  logic        inc_day;
  logic [3:0]  month;
  logic [11:0] year;
  logic        load;
  logic [4:0]  load_day;
  logic [4:0]  day;
  logic        inc_month;
  logic [4:0]  dim;

  typedef struct {
    int day;
    int inc;
    int dim;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_day  = 1;
  int   m_inc  = 0;

  cnt_day_cal #(.YEAR_W(12), .DAY_RST(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc_day   (inc_day),
    .month     (month),
    .year      (year),
    .load      (load),
    .load_day  (load_day),
    .day       (day),
    .inc_month (inc_month),
    .dim       (dim)
  );

  always #5 clk = ~clk;

  function automatic int model_dim(input int mo, input int yr);
    int  lens[16] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31, 31, 31, 31};
    bit  leap;
    leap = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
    if (mo == 2 && leap) return 29;
    return lens[mo];
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the model's post-edge expectation.
  task automatic applyStimulus(input bit r, input bit i, input int mo, input int yr,
                               input bit ld, input int ldd);
    int d;
    @(negedge clk);
    rst      = r;
    inc_day  = i;
    month    = 4'(mo);
    year     = 12'(yr);
    load     = ld;
    load_day = 5'(ldd);
    d = model_dim(mo & 15, yr & 4095);
    if (r) begin
      m_day = 1;
      m_inc = 0;
    end else if (ld) begin
      m_day = (ldd == 0) ? 1 : ((ldd > d) ? d : ldd);
      m_inc = 0;
    end else if (i) begin
      if (m_day >= d) begin
        m_day = 1;
        m_inc = 1;
      end else begin
        m_day = m_day + 1;
        m_inc = 0;
      end
    end else begin
      m_inc = 0;
    end
    sb.push_back('{m_day, m_inc, d});
  endtask

  task automatic ticks(input int n, input int mo, input int yr);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, mo, yr, 0, 0);
  endtask

  // Monitor: one registered result per clock, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("day", int'(day), e.day);
        checkOutput("inc_month", int'(inc_month), e.inc);
        checkOutput("dim", int'(dim), e.dim);
      end
    end
  end

  initial begin
    int years[6] = '{0, 1900, 2000, 2023, 2024, 2100};
    int feb_years[4] = '{2024, 2023, 1900, 2000};
    int mo, yr, guard;
    rst = 1'b1; inc_day = 1'b0; month = 4'd1; year = 12'd2023;
    load = 1'b0; load_day = 5'd0;

    applyStimulus(1, 0, 1, 2023, 0, 0);
    applyStimulus(1, 0, 1, 2023, 0, 0);
    applyStimulus(1, 1, 1, 2023, 0, 0);

    ticks(31, 1, 2023);
    applyStimulus(0, 0, 1, 2023, 0, 0);

    foreach (feb_years[k]) begin
      applyStimulus(0, 0, 2, feb_years[k], 1, 1);
      ticks(model_dim(2, feb_years[k]), 2, feb_years[k]);
      applyStimulus(0, 0, 2, feb_years[k], 0, 0);
    end

    applyStimulus(0, 0, 4, 2023, 1, 31);
    applyStimulus(0, 0, 4, 2023, 1, 0);
    applyStimulus(0, 1, 4, 2023, 1, 15);
    applyStimulus(0, 0, 4, 2023, 0, 0);

    applyStimulus(0, 0, 1, 2023, 1, 31);
    applyStimulus(0, 1, 2, 2023, 0, 0);
    applyStimulus(0, 0, 2, 2023, 0, 0);

    applyStimulus(0, 0, 6, 2023, 1, 30);
    ticks(2, 6, 2023);
    applyStimulus(0, 0, 6, 2023, 0, 0);

    mo = 1;
    yr = 2023;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) mo = $urandom_range(0, 15);
      if ($urandom_range(0, 99) == 0)
        yr = ($urandom_range(0, 1) == 1) ? years[$urandom_range(0, 5)] : $urandom_range(0, 4095);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, mo, yr,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 31));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
